// File: rtl/ame_pkg.sv
// Shared widths, stage payload type and the b -> power-of-two rounding helper.
// AME_ROUND_EN selects nearest-power rounding; undefined gives floor (truncation).
package ame_pkg;

  localparam int AME_DATA_W  = 16;
  localparam int AME_PROD_W  = 32;
  localparam int AME_SHIFT_W = 5;
  localparam int AME_OH_W    = AME_DATA_W + 1;

  // code holds the one-hot in S1 and the zero-extended shift amount in S2.
  typedef struct packed {
    logic [AME_DATA_W-1:0] a;
    logic [AME_OH_W-1:0]   code;
    logic                  zero;
  } ame_stage_t;

  function automatic logic [AME_OH_W-1:0] ame_b_to_onehot(input logic [AME_DATA_W-1:0] b);
    logic [3:0]          msb;
    logic [AME_OH_W-1:0] oh;
    msb = '0;
    oh  = '0;
    for (int i = 0; i < AME_DATA_W; i++) begin
      if (b[i]) msb = 4'(i);
    end
    if (b != '0) begin
      oh = {{(AME_OH_W-1){1'b0}}, 1'b1} << msb;
`ifdef AME_ROUND_EN
      // Bit below the MSB set means b >= 1.5 * 2^k, so the upper power is nearer.
      if (msb != 4'd0 && b[msb - 4'd1]) oh = oh << 1;
`endif
    end
    return oh;
  endfunction

endpackage

// File: rtl/ame_oh2bin.sv
// Combinational one-hot to binary index encoder (S2 of ame_shift_mul).
// An all-zero input encodes to index 0.
module ame_oh2bin
  import ame_pkg::*;
(
  input  logic [AME_OH_W-1:0]    oh_i,
  output logic [AME_SHIFT_W-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < AME_OH_W; i++) begin
      if (oh_i[i]) idx_o = idx_o | AME_SHIFT_W'(i);
    end
  end

endmodule

// File: rtl/ame_shift_mul.sv
// Approximate multiplier: a * 2^round(log2 b) as a 3-stage elastic pipeline.
// Rounding mode is chosen by the AME_ROUND_EN macro (see ame_pkg).
//
// Handshake: a transfer happens on a rising edge where valid && ready; valid
// never depends on ready, ready may depend combinationally on downstream ready.
module ame_shift_mul
  import ame_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [AME_DATA_W-1:0]  a_i,
  input  logic [AME_DATA_W-1:0]  b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [AME_PROD_W-1:0]  prod_o,
  output logic [AME_SHIFT_W-1:0] shift_o,
  output logic                   zero_o
);

  logic                   s1_valid_q, s2_valid_q, s3_valid_q;
  ame_stage_t             s1_q, s1_d, s2_q, s2_d;
  logic [AME_PROD_W-1:0]  prod_q, prod_d;
  logic [AME_SHIFT_W-1:0] shift_q, shift_d;
  logic                   zero_q, zero_d;
  logic [AME_SHIFT_W-1:0] s2_shift;
  logic                   s1_ready, s2_ready, s3_ready;

  // A stage may load when it is empty or its content moves on this cycle.
  assign s3_ready   = !s3_valid_q || out_ready_i;
  assign s2_ready   = !s2_valid_q || s3_ready;
  assign s1_ready   = !s1_valid_q || s2_ready;
  assign in_ready_o = s1_ready;

  ame_oh2bin u_oh2bin (
    .oh_i  (s1_q.code),
    .idx_o (s2_shift)
  );

  always_comb begin
    s1_d.a    = a_i;
    s1_d.code = ame_b_to_onehot(b_i);
    s1_d.zero = (b_i == '0);

    s2_d.a    = s1_q.a;
    s2_d.code = {{(AME_OH_W-AME_SHIFT_W){1'b0}}, s2_shift};
    s2_d.zero = s1_q.zero;

    // b = 0 encodes to shift 0, so the product must be forced to zero here.
    prod_d  = s2_q.zero ? '0 : (AME_PROD_W'(s2_q.a) << s2_q.code);
    shift_d = s2_q.code[AME_SHIFT_W-1:0];
    zero_d  = s2_q.zero;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      prod_q     <= '0;
      shift_q    <= '0;
      zero_q     <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= in_valid_i;
        if (in_valid_i) s1_q <= s1_d;
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_q <= s2_d;
      end
      if (s3_ready) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          prod_q  <= prod_d;
          shift_q <= shift_d;
          zero_q  <= zero_d;
        end
      end
    end
  end

  assign out_valid_o = s3_valid_q;
  assign prod_o      = prod_q;
  assign shift_o     = shift_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_ame_shift_mul.sv
// Scoreboard bench for ame_shift_mul; expected values follow AME_ROUND_EN.
module tb_ame_shift_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] prod;
  logic [4:0]  shift;
  logic        zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int first_stall = -1;
  bit mon_en = 1'b0;
  bit head_seen = 1'b0;
  bit rand_done;

  logic [37:0] exp_q[$];
  int          lat_q[$];

  logic [15:0] va[8], vb[8];
  logic [31:0] vp[8];
  logic [4:0]  vs[8];
  logic        vz[8];

  ame_shift_mul dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (in_a),
    .b_i         (in_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .prod_o      (prod),
    .shift_o     (shift),
    .zero_o      (zero)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [37:0] pack(input logic [31:0] p, input logic [4:0] s, input logic z);
    return {p, s, z};
  endfunction

  // Independent formulation: largest power of two <= b, then compare 2b to 3*2^p.
  function automatic logic [37:0] ref_model(input logic [15:0] a, input logic [15:0] b);
    int p;
    if (b == 16'd0) return pack(32'd0, 5'd0, 1'b1);
    p = 0;
    for (int i = 0; i < 16; i++) if ((32'd1 << i) <= {16'd0, b}) p = i;
`ifdef AME_ROUND_EN
    if (2 * {16'd0, b} >= 3 * (32'd1 << p)) p = p + 1;
`endif
    return pack({16'd0, a} * (32'd1 << p), 5'(p), 1'b0);
  endfunction

  task automatic init_vectors();
    va[0] = 16'd3;    vb[0] = 16'd6;    vz[0] = 0;
    va[1] = 16'hFFFF; vb[1] = 16'hC000; vz[1] = 0;
    va[2] = 16'h1234; vb[2] = 16'd0;    vz[2] = 1; vp[2] = 32'd0; vs[2] = 5'd0;
    va[3] = 16'd5;    vb[3] = 16'd1;    vz[3] = 0; vp[3] = 32'd5;       vs[3] = 5'd0;
    va[4] = 16'h00FF; vb[4] = 16'h8000; vz[4] = 0; vp[4] = 32'h007F8000; vs[4] = 5'd15;
    va[5] = 16'd7;    vb[5] = 16'hBFFF; vz[5] = 0; vp[5] = 32'h00038000; vs[5] = 5'd15;
    va[6] = 16'h0100; vb[6] = 16'd3;    vz[6] = 0;
    va[7] = 16'd9;    vb[7] = 16'd5;    vz[7] = 0; vp[7] = 32'd36;      vs[7] = 5'd2;
`ifdef AME_ROUND_EN
    vp[0] = 32'd24;        vs[0] = 5'd3;
    vp[1] = 32'hFFFF0000;  vs[1] = 5'd16;
    vp[6] = 32'h00000400;  vs[6] = 5'd2;
`else
    vp[0] = 32'd12;        vs[0] = 5'd2;
    vp[1] = 32'h7FFF8000;  vs[1] = 5'd15;
    vp[6] = 32'h00000200;  vs[6] = 5'd1;
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [37:0] e,
                       input bit lat);
    int n;
    in_a = a; in_b = b; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      if (first_stall < 0) first_stall = n_acc;
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL drive_timeout in_ready=%b expected=1", in_ready);
    end else begin
      exp_q.push_back(e);
      lat_q.push_back(lat ? cyc : -1);
      n_acc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output prod=%h shift=%0d zero=%b expected=none",
                 prod, shift, zero);
      end else begin
        if ({prod, shift, zero} !== exp_q[0]) begin
          errors++;
          $display("FAIL result prod=%h shift=%0d zero=%b expected prod=%h shift=%0d zero=%b",
                   prod, shift, zero, exp_q[0][37:6], exp_q[0][5:1], exp_q[0][0]);
        end
        if (!head_seen) begin
          head_seen = 1'b1;
          if (lat_q[0] >= 0) begin
            checks++;
            if (cyc - lat_q[0] != 3) begin
              errors++;
              $display("FAIL latency got=%0d expected=3", cyc - lat_q[0]);
            end
          end
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    init_vectors();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_prod", prod, 32'd0);
    chk("reset_shift", 32'(shift), 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed vectors back to back, consumer always ready, latency checked.
    for (int i = 0; i < 8; i++) drive(va[i], vb[i], pack(vp[i], vs[i], vz[i]), 1'b1);
    in_valid = 1'b0;
    drain();

    // Burst of 8 with the consumer stalled for 5 cycles.
    first_stall = -1; n_acc = 0;
    fork
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) drive(va[7-i], vb[7-i], pack(vp[7-i], vs[7-i], vz[7-i]), 1'b0);
        in_valid = 1'b0;
      end
    join
    chk("accepts_before_stall", 32'(first_stall), 32'd3);
    drain();

    // Mid-flight reset with 3 operands in the pipe.
    for (int i = 0; i < 3; i++) drive(va[i], vb[i], pack(vp[i], vs[i], vz[i]), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete(); lat_q.delete(); head_seen = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_no_stale", 32'(out_valid), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    drive(va[0], vb[0], pack(vp[0], vs[0], vz[0]), 1'b1);
    in_valid = 1'b0;
    drain();

    // Random operands with random consumer stalls against the model.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [15:0] ra, rb;
          ra = 16'($urandom_range(0, 65535));
          rb = 16'($urandom_range(0, 65535)) >> $urandom_range(0, 15);
          drive(ra, rb, ref_model(ra, rb), 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
